// File: rtl/bf_pkg.sv
// Beamformer shared definitions: sample width, default channel/delay sizing,
// packed {I,Q} sample type and the channel-slice helper macro.
package bf_pkg;
  localparam int BF_W         = 18;
  localparam int BF_NCH       = 4;
  localparam int BF_MAX_DELAY = 15;

  typedef struct packed {
    logic signed [BF_W-1:0] i;
    logic signed [BF_W-1:0] q;
  } iq_t;
endpackage

`ifndef BF_CH_SLICE
`define BF_CH_SLICE(c, w) ((c)*(w)) +: (w)
`endif

// File: rtl/dly_ring_ch.sv
// One channel of the programmable delay line: {I,Q} ring RAM, d=0 bypass,
// zero-fill gating while history is short, and the output register.
module dly_ring_ch
  import bf_pkg::*;
#(
  parameter int W         = BF_W,
  parameter int MAX_DELAY = BF_MAX_DELAY,
  parameter int AW        = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] wr_ptr,
  input  logic [AW-1:0] delay,
  input  logic [AW-1:0] fill_cnt,
  input  logic [W-1:0]  din_i,
  input  logic [W-1:0]  din_q,
  output logic [W-1:0]  dout_i,
  output logic [W-1:0]  dout_q
);
  // Modulo arithmetic in AW bits is exact whether or not the depth is a power of 2.
  localparam logic [AW-1:0] DEPTH_L = AW'(MAX_DELAY + 1);

  logic [2*W-1:0] ram [MAX_DELAY+1];
  logic [AW-1:0]  rd_addr;
  logic [2*W-1:0] rd_data;
  logic [2*W-1:0] data_d;
  logic [2*W-1:0] data_q;

  assign rd_addr = (wr_ptr >= delay) ? (wr_ptr - delay)
                                     : AW'(wr_ptr + DEPTH_L - delay);

  always_ff @(posedge clk) begin
    if (in_valid) ram[wr_ptr] <= {din_i, din_q};
  end

  assign rd_data = ram[rd_addr];

  always_comb begin
    data_d = rd_data;
    if (delay == '0)            data_d = {din_i, din_q};
    else if (delay > fill_cnt)  data_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        data_q <= '0;
    else if (in_valid) data_q <= data_d;
  end

  assign dout_i = data_q[2*W-1:W];
  assign dout_q = data_q[W-1:0];
endmodule

// File: rtl/delay_line_prog_iq.sv
// Multi-channel I/Q delay line with a run-time programmable per-channel delay
// counted in in_valid strobes; shared write pointer and fill counter.
module delay_line_prog_iq
  import bf_pkg::*;
#(
  parameter int W         = BF_W,
  parameter int NCH       = BF_NCH,
  parameter int MAX_DELAY = BF_MAX_DELAY,
  localparam int DW       = $clog2(MAX_DELAY + 1),
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [NCH*W-1:0] din_i,
  input  logic [NCH*W-1:0] din_q,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [DW:0]    cfg_delay,
  output logic           cfg_err,
  output logic           out_valid,
  output logic [NCH*W-1:0] dout_i,
  output logic [NCH*W-1:0] dout_q
);
  localparam logic [DW:0] MAX_L = (DW+1)'(MAX_DELAY);
  localparam logic [CW:0] NCH_L = (CW+1)'(NCH);

  logic [DW-1:0] wr_ptr_q;
  logic [DW-1:0] fill_cnt_q;
  logic          out_valid_q;
  logic          cfg_err_q;
  logic          ch_ok;
  logic          delay_ok;
  logic [DW-1:0] cfg_delay_sat;

  assign ch_ok         = {1'b0, cfg_ch} < NCH_L;
  assign delay_ok      = cfg_delay <= MAX_L;
  assign cfg_delay_sat = delay_ok ? cfg_delay[DW-1:0] : MAX_L[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      cfg_err_q   <= cfg_we && !(ch_ok && delay_ok);
      if (in_valid) begin
        wr_ptr_q <= (wr_ptr_q == MAX_L[DW-1:0]) ? '0 : wr_ptr_q + 1'b1;
        if (fill_cnt_q != MAX_L[DW-1:0]) fill_cnt_q <= fill_cnt_q + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [DW-1:0] delay_q;

    // A same-cycle strobe sees the old delay because the ring reads delay_q.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        delay_q <= '0;
      else if (cfg_we && ch_ok && (cfg_ch == CW'(gi)))
        delay_q <= cfg_delay_sat;
    end

    dly_ring_ch #(
      .W         (W),
      .MAX_DELAY (MAX_DELAY),
      .AW        (DW)
    ) u_ring (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .wr_ptr   (wr_ptr_q),
      .delay    (delay_q),
      .fill_cnt (fill_cnt_q),
      .din_i    (din_i[`BF_CH_SLICE(gi, W)]),
      .din_q    (din_q[`BF_CH_SLICE(gi, W)]),
      .dout_i   (dout_i[`BF_CH_SLICE(gi, W)]),
      .dout_q   (dout_q[`BF_CH_SLICE(gi, W)])
    );
  end
endmodule

// File: tb/tb_delay_line_prog_iq.sv
// Self-checking bench: randomized and ramp stimulus compared against a
// strobe-indexed history model of the delay line.
module tb_delay_line_prog_iq;
  import bf_pkg::*;

  localparam int W    = 18;
  localparam int NCH  = 4;
  localparam int MAXD = 15;
  localparam int DW   = 4;
  localparam int CW   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [NCH*W-1:0] din_i = '0;
  logic [NCH*W-1:0] din_q = '0;
  logic             cfg_we = 1'b0;
  logic [CW-1:0]    cfg_ch = '0;
  logic [DW:0]      cfg_delay = '0;
  logic             cfg_err;
  logic             out_valid;
  logic [NCH*W-1:0] dout_i;
  logic [NCH*W-1:0] dout_q;

  // Three-channel instance so that cfg_ch = NCH is expressible on a 2-bit port.
  logic             in3_valid = 1'b0;
  logic [3*W-1:0]   din3_i = '0;
  logic [3*W-1:0]   din3_q = '0;
  logic             cfg3_we = 1'b0;
  logic [1:0]       cfg3_ch = '0;
  logic [DW:0]      cfg3_delay = '0;
  logic             cfg3_err;
  logic             out3_valid;
  logic [3*W-1:0]   dout3_i;
  logic [3*W-1:0]   dout3_q;

  always #5 clk = ~clk;

  delay_line_prog_iq #(.W(W), .NCH(NCH), .MAX_DELAY(MAXD)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din_i(din_i), .din_q(din_q),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_err(cfg_err),
    .out_valid(out_valid), .dout_i(dout_i), .dout_q(dout_q)
  );

  delay_line_prog_iq #(.W(W), .NCH(3), .MAX_DELAY(MAXD)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in3_valid), .din_i(din3_i), .din_q(din3_q),
    .cfg_we(cfg3_we), .cfg_ch(cfg3_ch), .cfg_delay(cfg3_delay), .cfg_err(cfg3_err),
    .out_valid(out3_valid), .dout_i(dout3_i), .dout_q(dout3_q)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [NCH*W-1:0] hist_i[$];
  logic [NCH*W-1:0] hist_q[$];
  int               dly_m[NCH];
  logic [NCH*W-1:0] exp_i = '0;
  logic [NCH*W-1:0] exp_q = '0;
  logic             exp_ov = 1'b0;
  logic             exp_err = 1'b0;

  task automatic check(input string tag, input logic [NCH*W-1:0] got, input logic [NCH*W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist_i.delete();
    hist_q.delete();
    for (int c = 0; c < NCH; c++) dly_m[c] = 0;
    exp_i = '0; exp_q = '0; exp_ov = 1'b0; exp_err = 1'b0;
  endtask

  // Output for strobe k is the input of strobe k-d, zero when that strobe never happened.
  task automatic model_edge();
    int k;
    int d;
    exp_ov  = in_valid;
    exp_err = cfg_we && ((int'(cfg_delay) > MAXD) || (int'(cfg_ch) >= NCH));
    if (in_valid) begin
      k = hist_i.size();
      for (int c = 0; c < NCH; c++) begin
        d = dly_m[c];
        if (d == 0) begin
          exp_i[c*W +: W] = din_i[c*W +: W];
          exp_q[c*W +: W] = din_q[c*W +: W];
        end else if (d > k) begin
          exp_i[c*W +: W] = '0;
          exp_q[c*W +: W] = '0;
        end else begin
          exp_i[c*W +: W] = hist_i[k-d][c*W +: W];
          exp_q[c*W +: W] = hist_q[k-d][c*W +: W];
        end
      end
      hist_i.push_back(din_i);
      hist_q.push_back(din_q);
    end
    if (cfg_we && (int'(cfg_ch) < NCH))
      dly_m[cfg_ch] = (int'(cfg_delay) > MAXD) ? MAXD : int'(cfg_delay);
  endtask

  // One clock: drive at negedge, model at posedge, compare at the next negedge.
  task automatic step(input logic v, input logic we, input int ch, input int dl, input int ramp);
    in_valid  = v;
    cfg_we    = we;
    cfg_ch    = CW'(ch);
    cfg_delay = (DW+1)'(dl);
    for (int c = 0; c < NCH; c++) begin
      din_i[c*W +: W] = (ramp != 0) ? W'(ramp)  : W'($urandom);
      din_q[c*W +: W] = (ramp != 0) ? W'(-ramp) : W'($urandom);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("out_valid", {{(NCH*W-1){1'b0}}, out_valid}, {{(NCH*W-1){1'b0}}, exp_ov});
    check("cfg_err",   {{(NCH*W-1){1'b0}}, cfg_err},   {{(NCH*W-1){1'b0}}, exp_err});
    check("dout_i", dout_i, exp_i);
    check("dout_q", dout_q, exp_q);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic set_all(input int dl);
    for (int c = 0; c < NCH; c++) step(1'b0, 1'b1, c, dl, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ov"},  {{(NCH*W-1){1'b0}}, out_valid}, '0);
    check({tag, "_err"}, {{(NCH*W-1){1'b0}}, cfg_err},   '0);
    check({tag, "_i"}, dout_i, '0);
    check({tag, "_q"}, dout_q, '0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Fixed delay 3, ramp stream: strobes 1..3 are zero, strobe 4 gives 1/-1.
    set_all(3);
    for (int r = 1; r <= 20; r++) begin
      step(1'b1, 1'b0, 0, 0, r);
      if (r == 3) check("ramp_s3_i", {{((NCH-1)*W){1'b0}}, dout_i[W-1:0]}, '0);
      if (r == 4) check("ramp_s4_i", {{((NCH-1)*W){1'b0}}, dout_i[W-1:0]}, 1);
      if (r == 4) check("ramp_s4_q", {{((NCH-1)*W){1'b0}}, dout_q[W-1:0]}, {{((NCH-1)*W){1'b0}}, {W{1'b1}}});
    end

    // Mixed delays with strobes on alternating clocks.
    step(1'b0, 1'b1, 0, 0, 0);
    step(1'b0, 1'b1, 1, 1, 0);
    step(1'b0, 1'b1, 2, 7, 0);
    step(1'b0, 1'b1, 3, 15, 0);
    for (int n = 0; n < 60; n++) step(n[0], 1'b0, 0, 0, 0);

    // Asynchronous reset mid-stream, between clock edges.
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check_zero_outputs("held_rst");
    rst_n = 1'b1;

    // Wrap-around at d=15 with a ramp: strobe 32 returns strobe 17.
    set_all(15);
    for (int r = 1; r <= 40; r++) begin
      step(1'b1, 1'b0, 0, 0, r);
      if (r == 15) check("wrap_s15", {{((NCH-1)*W){1'b0}}, dout_i[3*W +: W]}, '0);
      if (r == 16) check("wrap_s16", {{((NCH-1)*W){1'b0}}, dout_i[3*W +: W]}, 1);
      if (r == 32) check("wrap_s32", {{((NCH-1)*W){1'b0}}, dout_i[3*W +: W]}, 17);
    end

    // Config in the same cycle as a strobe: that strobe keeps the old delay.
    step(1'b0, 1'b1, 1, 3, 0);
    for (int n = 0; n < 6; n++) step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 1, 5, 0);
    for (int n = 0; n < 6; n++) step(1'b1, 1'b0, 0, 0, 0);

    // Illegal delay saturates to the maximum and pulses cfg_err once.
    step(1'b0, 1'b1, 2, 20, 0);
    step(1'b0, 1'b0, 0, 0, 0);
    for (int n = 0; n < 20; n++) step(1'b1, 1'b0, 0, 0, 0);

    // Illegal channel on the three-channel instance.
    cfg3_we = 1'b1; cfg3_ch = 2'd3; cfg3_delay = 5'd2;
    @(posedge clk); @(negedge clk);
    cfg3_we = 1'b0;
    check("cfg3_err_ch", {{(NCH*W-1){1'b0}}, cfg3_err}, 1);
    in3_valid = 1'b1; din3_i = 54'($urandom) ^ (54'($urandom) << 27); din3_q = 54'($urandom);
    @(posedge clk); @(negedge clk);
    in3_valid = 1'b0;
    check("cfg3_err_pulse", {{(NCH*W-1){1'b0}}, cfg3_err}, '0);
    check("cfg3_nochange_i", {{W{1'b0}}, dout3_i}, {{W{1'b0}}, din3_i});
    check("cfg3_nochange_q", {{W{1'b0}}, dout3_q}, {{W{1'b0}}, din3_q});
    cfg3_we = 1'b1; cfg3_ch = 2'd2; cfg3_delay = 5'd2;
    @(posedge clk); @(negedge clk);
    cfg3_we = 1'b0;
    check("cfg3_err_legal", {{(NCH*W-1){1'b0}}, cfg3_err}, '0);

    // Random soak with occasional (sometimes illegal) reconfiguration.
    for (int n = 0; n < 600; n++)
      step(($urandom % 3) != 0, ($urandom % 8) == 0, int'($urandom % NCH), int'($urandom % 20), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
